// File: rtl/axi4_wr_arbiter_if.sv
// AXI4 write-channel bundle (AW, W, B) for the write arbiter.
// N lanes are packed side by side, lane 0 in the low slice. BRESP is a
// single shared 2-bit field regardless of N.
interface axi4_wr_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [N*ADDR_WIDTH-1:0]     AWADDR;
    logic [2*N-1:0]              AWBURST;
    logic [3*N-1:0]              AWSIZE;
    logic [8*N-1:0]              AWLEN;
    logic [N-1:0]                AWVALID;
    logic [N-1:0]                AWREADY;
    logic [N*DATA_WIDTH-1:0]     WDATA;
    logic [N*DATA_WIDTH/8-1:0]   WSTRB;
    logic [N-1:0]                WLAST;
    logic [N-1:0]                WVALID;
    logic [N-1:0]                WREADY;
    logic [1:0]                  BRESP;
    logic [N-1:0]                BVALID;
    logic [N-1:0]                BREADY;

    modport master (
        output AWADDR, AWBURST, AWSIZE, AWLEN, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWBURST, AWSIZE, AWLEN, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// Two-requester AXI4 write arbiter. Round-robin grant, held from AW
// acceptance through the B handshake so bursts never interleave.
// Optional macro AXI4_WR_ARB_BEAT_CHECK_EN: arbiter generates WLAST from
// the accepted AWLEN and raises a sticky ERR when the requester's WLAST
// disagrees with it.
module axi4_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi4_wr_arbiter_if.slave  S,
    axi4_wr_arbiter_if.master M,
    output logic [1:0]        GRANT,
    output logic              ERR
);
    localparam int NUM_REQ = 2;
    localparam int STRB_W  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t             state, state_nxt;
    logic               gnt, gnt_nxt;
    logic               rr, rr_nxt;
    logic               aw_hs, w_hs, b_hs, wlast;
    logic [NUM_REQ-1:0] own, aw_rdy, w_rdy, b_vld;

    assign aw_hs = M.AWVALID && M.AWREADY;
    assign w_hs  = M.WVALID && M.WREADY;
    assign b_hs  = M.BVALID && M.BREADY;

    // State, registered grant index and round-robin preference
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            gnt   <= 1'b0;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            rr    <= rr_nxt;
        end
    end

    // Arbitrate in IDLE, then walk AW -> W -> B for the granted requester
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr;
        case (state)
            IDLE: if (|S.AWVALID) begin
                gnt_nxt   = (&S.AWVALID) ? rr : S.AWVALID[1];
                state_nxt = ADDR;
            end
            ADDR: if (aw_hs) state_nxt = DATA;
            DATA: if (w_hs && wlast) state_nxt = RESP;
            RESP: if (b_hs) begin
                rr_nxt    = ~gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-requester ownership; only the owner sees READY/BVALID
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign own[g]    = (state != IDLE) && (int'(gnt) == g);
        assign aw_rdy[g] = own[g] && (state == ADDR) && M.AWREADY;
        assign w_rdy[g]  = own[g] && (state == DATA) && M.WREADY;
        assign b_vld[g]  = own[g] && (state == RESP) && M.BVALID;
    end

    assign GRANT     = own;
    assign S.AWREADY = aw_rdy;
    assign S.WREADY  = w_rdy;
    assign S.BVALID  = b_vld;
    assign S.BRESP   = M.BRESP;

    // Forward the granted requester downstream; VALIDs gated by state
    always_comb begin
        M.AWADDR  = gnt ? S.AWADDR[ADDR_WIDTH +: ADDR_WIDTH] : S.AWADDR[0 +: ADDR_WIDTH];
        M.AWBURST = gnt ? S.AWBURST[3:2] : S.AWBURST[1:0];
        M.AWSIZE  = gnt ? S.AWSIZE[5:3]  : S.AWSIZE[2:0];
        M.AWLEN   = gnt ? S.AWLEN[15:8]  : S.AWLEN[7:0];
        M.WDATA   = gnt ? S.WDATA[DATA_WIDTH +: DATA_WIDTH] : S.WDATA[0 +: DATA_WIDTH];
        M.WSTRB   = gnt ? S.WSTRB[STRB_W +: STRB_W] : S.WSTRB[0 +: STRB_W];
        M.WLAST   = wlast;
        M.AWVALID = (state == ADDR) && S.AWVALID[gnt];
        M.WVALID  = (state == DATA) && S.WVALID[gnt];
        M.BREADY  = (state == RESP) && S.BREADY[gnt];
    end

`ifdef AXI4_WR_ARB_BEAT_CHECK_EN
    logic [7:0] beat_cnt;
    logic       err_q;

    // Remaining beats after the current one; zero marks the last beat
    assign wlast = (beat_cnt == 8'd0);
    assign ERR   = err_q;

    // Load AWLEN on acceptance, count W beats, latch any WLAST disagreement
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            if (aw_hs)
                beat_cnt <= M.AWLEN;
            else if (w_hs)
                beat_cnt <= beat_cnt - 8'd1;
            if (w_hs && (S.WLAST[gnt] != wlast))
                err_q <= 1'b1;
        end
    end
`else
    assign wlast = S.WLAST[gnt];
    assign ERR   = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter: reset, single write, round-robin,
// backpressure, mid-burst reset, beat check and SLVERR routing.
module tb_axi4_wr_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [1:0] GRANT;
    logic       ERR;

    axi4_wr_arbiter_if #(.N(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
    axi4_wr_arbiter_if #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_if ();

    axi4_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .S       (s_if),
        .M       (m_if),
        .GRANT   (GRANT),
        .ERR     (ERR)
    );

    always #5 ACLK = ~ACLK;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic        w_rdy = 1'b1;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] logd[$];
    bit          logl[$];
    logic [1:0]  logg[$];
    int          aw_cyc[$];
    int          b_cyc[$];
    bit          s_bdone, s_blast;

    assign m_if.WREADY = w_rdy;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave model: log handshakes at negedge, answer each WLAST with one B
    initial begin
        m_if.BVALID = 1'b0;
        m_if.BRESP  = 2'b00;
        forever begin
            @(negedge ACLK);
            s_bdone = m_if.BVALID && m_if.BREADY;
            s_blast = 1'b0;
            if (m_if.AWVALID && m_if.AWREADY) aw_cyc.push_back(cyc);
            if (m_if.WVALID && m_if.WREADY) begin
                logd.push_back(m_if.WDATA);
                logl.push_back(m_if.WLAST);
                logg.push_back(GRANT);
                s_blast = m_if.WLAST;
            end
            if (s_bdone) b_cyc.push_back(cyc);
            @(posedge ACLK);
            #1;
            if (s_bdone || !ARESETn) m_if.BVALID = 1'b0;
            if (s_blast && ARESETn) begin
                m_if.BVALID = 1'b1;
                m_if.BRESP  = bresp_cfg;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

    task automatic clear_logs();
        logd.delete(); logl.delete(); logg.delete();
        aw_cyc.delete(); b_cyc.delete();
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        s_if.AWADDR = '0; s_if.AWBURST = '0; s_if.AWSIZE = '0; s_if.AWLEN = '0;
        s_if.AWVALID = '0; s_if.WDATA = '0; s_if.WSTRB = '0; s_if.WLAST = '0;
        s_if.WVALID = '0; s_if.BREADY = '0;
        m_if.AWREADY = 1'b1;
        w_rdy = 1'b1;
        bresp_cfg = 2'b00;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        clear_logs();
    endtask

    // Requester r: one AW, nbeats W beats (WLAST on beat wlast_idx), then B
    task automatic master_write(input int r, input logic [31:0] addr, input logic [7:0] len,
                                input logic [31:0] d0, input int nbeats, input int wlast_idx,
                                output logic [1:0] bresp, output logic [1:0] bvec);
        int t;
        bit hs;
        bit ok;
        bresp = 2'b11;
        bvec  = 2'b00;
        s_if.AWADDR[r*AW +: AW] = addr;
        s_if.AWBURST[r*2 +: 2]  = 2'b01;
        s_if.AWSIZE[r*3 +: 3]   = 3'd2;
        s_if.AWLEN[r*8 +: 8]    = len;
        s_if.AWVALID[r]         = 1'b1;
        hs = 0;
        t = 0;
        while (!hs && t < 200) begin
            @(negedge ACLK); hs = s_if.AWREADY[r]; @(posedge ACLK); #1; t++;
        end
        s_if.AWVALID[r] = 1'b0;
        ok = hs;
        for (int i = 0; i < nbeats && ok; i++) begin
            s_if.WDATA[r*DW +: DW]    = d0 + 32'(i);
            s_if.WSTRB[r*DW/8 +: DW/8] = '1;
            s_if.WLAST[r]             = (i == wlast_idx);
            s_if.WVALID[r]            = 1'b1;
            hs = 0;
            t = 0;
            while (!hs && t < 200) begin
                @(negedge ACLK); hs = s_if.WREADY[r]; @(posedge ACLK); #1; t++;
            end
            ok = hs;
        end
        s_if.WVALID[r] = 1'b0;
        s_if.WLAST[r]  = 1'b0;
        if (ok) begin
            s_if.BREADY[r] = 1'b1;
            hs = 0;
            t = 0;
            while (!hs && t < 200) begin
                @(negedge ACLK);
                if (s_if.BVALID[r]) begin
                    hs = 1; bresp = s_if.BRESP; bvec = s_if.BVALID;
                end
                @(posedge ACLK); #1; t++;
            end
            s_if.BREADY[r] = 1'b0;
            ok = hs;
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL xfer_timeout req%0d: transaction stalled, need completion", r);
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        #2;
        nvec++;
        if (GRANT !== 2'b00 || ERR !== 1'b0) begin
            nerr++; $display("FAIL rst_grant_err: got GRANT=%b ERR=%b, need 00 0", GRANT, ERR);
        end
        do_reset();
        @(negedge ACLK);
        nvec++;
        if ({m_if.AWVALID, m_if.WVALID, m_if.BREADY} !== 3'b000) begin
            nerr++; $display("FAIL rst_m_valid: got %b, need 000", {m_if.AWVALID, m_if.WVALID, m_if.BREADY});
        end
        nvec++;
        if ({s_if.AWREADY, s_if.WREADY, s_if.BVALID} !== 6'b0) begin
            nerr++; $display("FAIL rst_s_ready: got %b, need 000000", {s_if.AWREADY, s_if.WREADY, s_if.BVALID});
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_single();
        logic [1:0] br, bv;
        do_reset();
        fork
            master_write(0, 32'h100, 8'd3, 32'hA0, 4, 3, br, bv);
            begin
                @(negedge ACLK);
                nvec++;
                if (GRANT !== 2'b00) begin
                    nerr++; $display("FAIL single_lat0: got GRANT=%b, need 00", GRANT);
                end
                @(negedge ACLK);
                nvec++;
                if (GRANT !== 2'b01 || m_if.AWVALID !== 1'b1) begin
                    nerr++; $display("FAIL single_lat1: got GRANT=%b AWVALID=%b, need 01 1", GRANT, m_if.AWVALID);
                end
                nvec++;
                if (m_if.AWADDR !== 32'h100 || m_if.AWLEN !== 8'd3) begin
                    nerr++; $display("FAIL single_aw: got %h/%0d, need 100/3", m_if.AWADDR, m_if.AWLEN);
                end
            end
        join
        nvec++;
        if (logd.size() !== 4) begin
            nerr++; $display("FAIL single_nbeats: got %0d, need 4", logd.size());
        end
        for (int k = 0; k < 4 && k < logd.size(); k++) begin
            nvec++;
            if (logd[k] !== 32'hA0 + 32'(k) || logl[k] !== (k == 3)) begin
                nerr++; $display("FAIL single_beat%0d: got %h last=%0d, need %h last=%0d",
                                 k, logd[k], logl[k], 32'hA0 + 32'(k), (k == 3));
            end
        end
        nvec++;
        if (br !== 2'b00 || bv !== 2'b01) begin
            nerr++; $display("FAIL single_b: got resp=%b bvalid=%b, need 00 01", br, bv);
        end
        nvec++;
        if (GRANT !== 2'b00) begin
            nerr++; $display("FAIL single_idle: got GRANT=%b, need 00", GRANT);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] br0, bv0, br1, bv1;
        logic [31:0] exp_d [8];
        logic [1:0]  exp_g [8];
        exp_d = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h20, 32'h21, 32'h30, 32'h31};
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        do_reset();
        fork
            master_write(0, 32'h200, 8'd1, 32'h00, 2, 1, br0, bv0);
            master_write(1, 32'h300, 8'd1, 32'h10, 2, 1, br1, bv1);
        join
        fork
            master_write(0, 32'h240, 8'd1, 32'h20, 2, 1, br0, bv0);
            master_write(1, 32'h340, 8'd1, 32'h30, 2, 1, br1, bv1);
        join
        nvec++;
        if (logd.size() !== 8) begin
            nerr++; $display("FAIL rr_nbeats: got %0d, need 8", logd.size());
        end
        for (int k = 0; k < 8 && k < logd.size(); k++) begin
            nvec++;
            if (logd[k] !== exp_d[k] || logg[k] !== exp_g[k]) begin
                nerr++; $display("FAIL rr_beat%0d: got %h grant=%b, need %h grant=%b",
                                 k, logd[k], logg[k], exp_d[k], exp_g[k]);
            end
        end
        nvec++;
        if (aw_cyc.size() < 2 || b_cyc.size() < 1 || aw_cyc[1] - b_cyc[0] !== 2) begin
            nerr++; $display("FAIL b2b_gap: got %0d cycles, need 2",
                             (aw_cyc.size() > 1 && b_cyc.size() > 0) ? aw_cyc[1] - b_cyc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] br, bv;
        do_reset();
        fork
            master_write(0, 32'h100, 8'd3, 32'hA0, 4, 3, br, bv);
            begin
                for (int t = 0; t < 100 && logd.size() < 2; t++) @(negedge ACLK);
                @(posedge ACLK); #1;
                w_rdy = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge ACLK);
                    nvec++;
                    if (s_if.WREADY[0] !== 1'b0 || m_if.WVALID !== 1'b1) begin
                        nerr++; $display("FAIL bp_stall%0d: got WREADY=%b WVALID=%b, need 0 1",
                                         s, s_if.WREADY[0], m_if.WVALID);
                    end
                end
                @(posedge ACLK); #1;
                w_rdy = 1'b1;
                @(negedge ACLK);
                nvec++;
                if (s_if.WREADY[0] !== 1'b1) begin
                    nerr++; $display("FAIL bp_mirror: got WREADY=%b, need 1", s_if.WREADY[0]);
                end
            end
        join
        nvec++;
        if (logd.size() !== 4) begin
            nerr++; $display("FAIL bp_nbeats: got %0d, need 4", logd.size());
        end
        for (int k = 0; k < 4 && k < logd.size(); k++) begin
            nvec++;
            if (logd[k] !== 32'hA0 + 32'(k)) begin
                nerr++; $display("FAIL bp_beat%0d: got %h, need %h", k, logd[k], 32'hA0 + 32'(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] br, bv;
        bit hs;
        do_reset();
        s_if.AWADDR[31:0] = 32'h400; s_if.AWLEN[7:0] = 8'd7; s_if.AWVALID[0] = 1'b1;
        hs = 0;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge ACLK); hs = s_if.AWREADY[0]; @(posedge ACLK); #1;
        end
        s_if.AWVALID[0] = 1'b0;
        s_if.WDATA[31:0] = 32'hB0; s_if.WSTRB[3:0] = 4'hF; s_if.WVALID[0] = 1'b1;
        hs = 0;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge ACLK); hs = s_if.WREADY[0]; @(posedge ACLK); #1;
        end
        s_if.WDATA[31:0] = 32'hB1;
        @(negedge ACLK);
        nvec++;
        if (GRANT !== 2'b01 || m_if.WVALID !== 1'b1) begin
            nerr++; $display("FAIL rmid_pre: got GRANT=%b WVALID=%b, need 01 1", GRANT, m_if.WVALID);
        end
        ARESETn = 1'b0;
        #1;
        nvec++;
        if (GRANT !== 2'b00 || {m_if.AWVALID, m_if.WVALID, m_if.BREADY} !== 3'b000) begin
            nerr++; $display("FAIL rmid_m: got GRANT=%b mvalid=%b, need 00 000",
                             GRANT, {m_if.AWVALID, m_if.WVALID, m_if.BREADY});
        end
        nvec++;
        if ({s_if.AWREADY, s_if.WREADY, s_if.BVALID} !== 6'b0) begin
            nerr++; $display("FAIL rmid_s: got %b, need 000000", {s_if.AWREADY, s_if.WREADY, s_if.BVALID});
        end
        s_if.WVALID = '0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        clear_logs();
        master_write(1, 32'h500, 8'd0, 32'hC0, 1, 0, br, bv);
        nvec++;
        if (logd.size() !== 1 || logd[0] !== 32'hC0 || logg[0] !== 2'b10 || bv !== 2'b10) begin
            nerr++; $display("FAIL rmid_after: got n=%0d d=%h bvalid=%b, need 1 c0 10",
                             logd.size(), (logd.size() > 0) ? logd[0] : 32'hx, bv);
        end
    endtask

    task automatic test_beat_check();
        logic [1:0] br, bv;
        do_reset();
`ifdef AXI4_WR_ARB_BEAT_CHECK_EN
        master_write(0, 32'h600, 8'd1, 32'hD0, 2, 0, br, bv);
        nvec++;
        if (ERR !== 1'b1) begin
            nerr++; $display("FAIL bc_err: got ERR=%b, need 1", ERR);
        end
        nvec++;
        if (logd.size() !== 2 || logl[0] !== 1'b0 || logl[1] !== 1'b1) begin
            nerr++; $display("FAIL bc_wlast: got n=%0d, need 2 beats with last on beat 2", logd.size());
        end
`else
        master_write(0, 32'h600, 8'd1, 32'hD0, 1, 0, br, bv);
        nvec++;
        if (ERR !== 1'b0) begin
            nerr++; $display("FAIL bc_err: got ERR=%b, need 0", ERR);
        end
        nvec++;
        if (logd.size() !== 1 || logl[0] !== 1'b1) begin
            nerr++; $display("FAIL bc_wlast: got n=%0d, need 1 beat with last", logd.size());
        end
`endif
        nvec++;
        if (br !== 2'b00 || bv !== 2'b01) begin
            nerr++; $display("FAIL bc_b: got resp=%b bvalid=%b, need 00 01", br, bv);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] br, bv;
        do_reset();
        bresp_cfg = 2'b10;
        master_write(1, 32'h700, 8'd0, 32'hE0, 1, 0, br, bv);
        nvec++;
        if (br !== 2'b10 || bv !== 2'b10) begin
            nerr++; $display("FAIL slverr: got resp=%b bvalid=%b, need 10 10", br, bv);
        end
        bresp_cfg = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_beat_check();
        test_slverr();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
